data_mem_sweep: RTL and testbench
=================================

// Module: data_mem_sweep
// PURPOSE
//  Parametrised single-port-array data memory with separate read and write ports.
//  Reads are registered (1-cycle latency).
//  Clearing uses a hardware sweep FSM that zeroes one word per cycle.
//  It runs on Reset or on request, replacing the single-cycle array reset.
//  Sits on the processor's load/store path; Busy stalls the core during a sweep.
// PARAMETERS
//  DATA_W  8  word width in bits
//  ADDR_W  8  address width; DEPTH = 2**ADDR_W words
// PORTS
//  Clk        in   1       clock, all state updates on posedge
//  Reset      in   1       synchronous, active-high
//  ClearReq   in   1       pulse: start a clear sweep (accepted only in IDLE)
//  WrEn       in   1       write enable
//  WrAddr     in   ADDR_W  write address
//  WrData     in   DATA_W  write data
//  RdEn       in   1       read enable
//  RdAddr     in   ADDR_W  read address
//  RdData     out  DATA_W  registered read data
//  RdValid    out  1       RdData updated this cycle (1-cycle pulse per read)
//  Busy       out  1       sweep in progress; core must not issue accesses
//  ParInject  in   1       [PARITY_EN only] invert stored parity bit on this write
//  ParityErr  out  1       [PARITY_EN only] parity mismatch on the read in RdData
// BEHAVIOUR
//  - Reset values: RdData=0, RdValid=0, ParityErr=0.
//    State=CLEAR with ClrAddr=0, so Busy=1 from the first cycle after Reset.
//  - States: IDLE, CLEAR.
//  - CLEAR: each posedge writes 0 to Core[ClrAddr], then ClrAddr++.
//    The cycle with ClrAddr==DEPTH-1 writes its word and moves to IDLE.
//    A sweep takes exactly DEPTH cycles.
//  - Busy = (state==CLEAR); it is a decode of the state register.
//  - IDLE -> CLEAR: on ClearReq=1 at a posedge, with ClrAddr loaded to 0.
//  - ClearReq while in CLEAR: ignored; the sweep does not restart.
//  - Reset in any state, including mid-sweep: ClrAddr=0 and the sweep restarts.
//  - In CLEAR: WrEn and RdEn are ignored. RdValid=0 and RdData holds its value.
//  - Write (IDLE, WrEn=1): Core[WrAddr] <= WrData at posedge.
//  - Read (IDLE, RdEn=1): at posedge, RdData <= Core[RdAddr] and RdValid <= 1.
//    Data is visible the cycle after the request.
//  - RdEn=0: RdValid <= 0 and RdData holds the last value.
//  - Same-cycle WrEn and RdEn with WrAddr==RdAddr: write-first bypass.
//    RdData <= WrData.
//  - Same-cycle WrEn and RdEn with different addresses: both are served.
//  - ClearReq together with WrEn/RdEn in IDLE: the access is served this cycle.
//    The sweep starts next cycle and overwrites any written word.
//  - All address arithmetic is modulo DEPTH.
//    There is no out-of-range condition because DEPTH = 2**ADDR_W.
// CONFIGURATION
//  Macro DATA_MEM_SWEEP_PARITY_EN.
//  - Defined:
//    - Each word stores one extra even-parity bit: ^WrData ^ ParInject.
//    - The sweep writes parity 0.
//    - On a read, ParityErr <= (^Core.data != Core.par), aligned with RdValid.
//    - A bypassed read takes its parity from the write path, so ParInject shows up.
//    - ParityErr=0 whenever RdValid=0.
//  - Undefined: the ParInject and ParityErr ports and the parity storage do not exist.
// TESTING
//  Defaults DATA_W=8, ADDR_W=8 (DEPTH=256).
//  1 Reset high 1 cycle -> Busy=1 for 256 cycles then 0.
//    Then read 0x00, 0x7F, 0xFF -> RdData=0x00, RdValid=1 one cycle after each RdEn.
//  2 Write 0xA5 @0x10; next cycle RdEn @0x10 -> cycle after: RdData=0xA5, RdValid=1.
//    Following idle cycle -> RdValid=0, RdData stays 0xA5.
//  3 Preload @0x20=0x00; same cycle WrEn @0x20=0x3C and RdEn @0x20 -> RdData=0x3C.
//    A read @0x21 concurrent with a write @0x20 -> RdData=old @0x21.
//  4 Write 0xFF @0xFF, pulse ClearReq -> Busy=1 for 256 cycles.
//    WrEn @0x01=0x55 mid-sweep -> ignored. After Busy falls, reads @0xFF and @0x01 -> 0x00.
//  5 ClearReq, then Reset asserted at sweep cycle 100 -> Busy stays 1.
//    Sweep ends 256 cycles after Reset deasserts.
//    A second ClearReq mid-sweep -> sweep length unchanged.
//  6 [PARITY_EN] Write 0x01 @0x05 with ParInject=1, read @0x05 -> ParityErr=1.
//    Write 0x01 @0x06 with ParInject=0, read @0x06 -> ParityErr=0.
//    After a sweep, read @0x05 -> ParityErr=0.

Source files
------------

// File: rtl/data_mem_sweep.sv
// Data memory with registered read and a hardware clear sweep.
// A sweep zeroes one word per cycle. It runs after Reset or after a ClearReq pulse.
// Busy is high while a sweep is running.
// Optional macro DATA_MEM_SWEEP_PARITY_EN adds one even-parity bit per word,
// together with the ParInject and ParityErr ports.
module data_mem_sweep #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
`ifdef DATA_MEM_SWEEP_PARITY_EN
  input  logic              ParInject,
  output logic              ParityErr,
`endif
  input  logic              ClearReq,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic              Busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   core [DEPTH];
  logic                wr_go, rd_go, bypass;

  // Accesses are honoured only in IDLE; Reset blocks them for that cycle.
  assign wr_go  = (state_q == StIdle) && WrEn && !Reset;
  assign rd_go  = (state_q == StIdle) && RdEn;
  assign bypass = WrEn && (WrAddr == RdAddr);
  assign Busy   = (state_q == StClear);

  // Next-state logic: the sweep finishes after writing the last word.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      StIdle: begin
        if (ClearReq) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end
      end
      StClear: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; Reset always restarts the sweep from address 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Storage array: the sweep writes zeros, otherwise the write port is used.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == StClear) core[clr_addr_q] <= '0;
      else if (wr_go)         core[WrAddr]     <= WrData;
    end
  end

  // Registered read with write-first bypass; RdData holds when no read is issued.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RdData  <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= rd_go;
      if (rd_go) RdData <= bypass ? WrData : core[RdAddr];
    end
  end

`ifdef DATA_MEM_SWEEP_PARITY_EN
  logic par_mem [DEPTH];

  // Parity storage follows the data array; the sweep stores parity 0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state_q == StClear) par_mem[clr_addr_q] <= 1'b0;
      else if (wr_go)         par_mem[WrAddr]     <= (^WrData) ^ ParInject;
    end
  end

  // On a bypassed read the stored parity would equal ^WrData ^ ParInject, so the error is ParInject.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ParityErr <= 1'b0;
    end else if (rd_go) begin
      ParityErr <= bypass ? ParInject : ((^core[RdAddr]) != par_mem[RdAddr]);
    end else begin
      ParityErr <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_sweep.sv
// Self-checking bench for data_mem_sweep: directed scenarios plus random traffic.
// Each step is compared against a behavioural model. The model clears the whole
// array at once and counts down the busy cycles.
module tb_data_mem_sweep;

  localparam int DEPTH = 256;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, ClearReq = 1'b0, WrEn = 1'b0, RdEn = 1'b0, ParInject = 1'b0;
  logic [7:0] WrAddr = '0, WrData = '0, RdAddr = '0;
  logic [7:0] RdData;
  logic       RdValid, Busy;
  logic       ParityErr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_mem [DEPTH];
  logic       m_par [DEPTH];
  int         m_busy = 0;
  logic [7:0] m_rd = '0;
  logic       m_rv = 1'b0, m_pe = 1'b0;

  always #5 Clk = ~Clk;

`ifdef DATA_MEM_SWEEP_PARITY_EN
  data_mem_sweep dut (
    .Clk(Clk), .Reset(Reset), .ParInject(ParInject), .ParityErr(ParityErr),
    .ClearReq(ClearReq), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData), .RdValid(RdValid), .Busy(Busy)
  );
`else
  assign ParityErr = 1'b0;
  data_mem_sweep dut (
    .Clk(Clk), .Reset(Reset),
    .ClearReq(ClearReq), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData), .RdValid(RdValid), .Busy(Busy)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare away from the edge.
  task automatic step(input logic rst, input logic clr, input logic we, input logic [7:0] wa,
                      input logic [7:0] wd, input logic re, input logic [7:0] ra,
                      input logic pinj);
    Reset = rst; ClearReq = clr; WrEn = we; WrAddr = wa; WrData = wd;
    RdEn = re; RdAddr = ra; ParInject = pinj;
    @(posedge Clk);
    if (rst) begin
      m_busy = DEPTH; m_rv = 1'b0; m_rd = '0; m_pe = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_par[i] = 1'b0; end
    end else if (m_busy > 0) begin
      m_busy--; m_rv = 1'b0; m_pe = 1'b0;
    end else begin
      m_rv = re;
      m_pe = 1'b0;
      if (re) begin
        if (we && wa == ra) begin
          m_rd = wd; m_pe = pinj;
        end else begin
          m_rd = m_mem[ra]; m_pe = (^m_mem[ra]) != m_par[ra];
        end
      end
      if (we) begin m_mem[wa] = wd; m_par[wa] = (^wd) ^ pinj; end
      if (clr) begin
        m_busy = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_par[i] = 1'b0; end
      end
    end
    #1;
    check("busy", 32'(Busy), 32'(m_busy > 0));
    check("rd_valid", 32'(RdValid), 32'(m_rv));
    check("rd_data", 32'(RdData), 32'(m_rd));
`ifdef DATA_MEM_SWEEP_PARITY_EN
    check("parity_err", 32'(ParityErr), 32'(m_pe));
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, a, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic pinj);
    step(1'b0, 1'b0, 1'b1, a, d, 1'b0, 8'h00, pinj);
  endtask

  // Run idle cycles until the sweep ends; returns the number of Busy samples seen.
  task automatic drain(output int cnt);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!Busy) break;
      cnt++;
      idle();
    end
  endtask

  int busy_cnt;

  initial begin
    // 1: reset sweep length, then reads of cleared words
    @(negedge Clk);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    check("t1_reset_rd_data", 32'(RdData), 32'h0);
    drain(busy_cnt);
    check("t1_sweep_len", 32'(busy_cnt), 32'd256);
    rd(8'h00); check("t1_rd00", 32'(RdData), 32'h00);
    rd(8'h7F); check("t1_rd7f", 32'(RdData), 32'h00);
    rd(8'hFF); check("t1_rdff_valid", 32'(RdValid), 32'h1);

    // 2: write then read, then hold
    wr(8'h10, 8'hA5, 1'b0);
    rd(8'h10); check("t2_rd", 32'(RdData), 32'hA5);
    idle();    check("t2_hold", 32'(RdData), 32'hA5);
    check("t2_valid_low", 32'(RdValid), 32'h0);

    // 3: write-first bypass and concurrent distinct-address access
    wr(8'h20, 8'h00, 1'b0);
    wr(8'h21, 8'h77, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h20, 8'h3C, 1'b1, 8'h20, 1'b0);
    check("t3_bypass", 32'(RdData), 32'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h20, 8'h99, 1'b1, 8'h21, 1'b0);
    check("t3_other", 32'(RdData), 32'h77);

    // 4: requested sweep ignores writes and clears the array
    wr(8'hFF, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) idle();
    wr(8'h01, 8'h55, 1'b0);
    drain(busy_cnt);
    rd(8'hFF); check("t4_rdff", 32'(RdData), 32'h00);
    rd(8'h01); check("t4_rd01", 32'(RdData), 32'h00);

    // 5: reset mid-sweep restarts; a repeated ClearReq does not extend it
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 99; i++) idle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    busy_cnt = Busy ? 1 : 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, (i == 50), 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      if (!Busy) break;
      busy_cnt++;
    end
    check("t5_sweep_len", 32'(busy_cnt), 32'd256);

`ifdef DATA_MEM_SWEEP_PARITY_EN
    // 6: parity injection, clean parity and post-sweep parity
    wr(8'h05, 8'h01, 1'b1);
    rd(8'h05); check("t6_inject", 32'(ParityErr), 32'h1);
    wr(8'h06, 8'h01, 1'b0);
    rd(8'h06); check("t6_clean", 32'(ParityErr), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    drain(busy_cnt);
    rd(8'h05); check("t6_after_sweep", 32'(ParityErr), 32'h0);
`endif

    // Random traffic with narrow address ranges to provoke collisions.
    for (int i = 0; i < 1500; i++) begin
      logic       r_rst, r_clr, r_we, r_re, r_pi;
      logic [7:0] r_wa, r_ra, r_wd;
      r_rst = ($urandom_range(0, 699) == 0);
      r_clr = ($urandom_range(0, 79) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_re  = $urandom_range(0, 1) == 1;
      r_pi  = ($urandom_range(0, 7) == 0);
      r_wd  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        r_wa = 8'($urandom_range(0, 7)); r_ra = 8'($urandom_range(0, 7));
      end else begin
        r_wa = 8'($urandom); r_ra = 8'($urandom);
      end
      step(r_rst, r_clr, r_we, r_wa, r_wd, r_re, r_ra, r_pi);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
